// File: rtl/c_ring_alloc.sv
// ---------------------------------------------------------------------------
// c_ring_alloc
//   Space allocator and pointer manager for a circular buffer addressed by
//   15-bit pointers. The producer side allocates regions (allocate FSM),
//   the consumer side releases them. Occupancy is wr - rd mod 2^15.
//
// Parameters
//   CAP      usable capacity in entries, 1..32767
//   STALL_W  width of the saturating allocate-stall counter
//
// Ports
//   iClock, iReset               clock, synchronous active-high reset
//   iAllocValid/iAllocLen        allocate request
//   oAllocReady                  allocate accepted (combinational)
//   oAllocDone/oAllocBase        grant pulse and start pointer of the region
//   iRelValid/iRelLen            release request
//   oRelReady                    release accepted (combinational)
//   oWrPtr/oRdPtr                write / read pointers
//   oUsed/oFree/oFull/oEmpty     occupancy status
//   oError                       sticky protocol error
//   oStallCnt                    cycles with allocate valid but not ready
// ---------------------------------------------------------------------------
module c_ring_alloc #(
  parameter int CAP     = 100,
  parameter int STALL_W = 16
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iAllocValid,
  input  logic [14:0]        iAllocLen,
  output logic               oAllocReady,
  output logic               oAllocDone,
  output logic [14:0]        oAllocBase,
  input  logic               iRelValid,
  input  logic [14:0]        iRelLen,
  output logic               oRelReady,
  output logic [14:0]        oWrPtr,
  output logic [14:0]        oRdPtr,
  output logic [14:0]        oUsed,
  output logic [14:0]        oFree,
  output logic               oFull,
  output logic               oEmpty,
  output logic               oError,
  output logic [STALL_W-1:0] oStallCnt
);

  localparam logic [14:0] CAP_L = 15'(CAP);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [14:0]         r_wr;
  logic [14:0]         r_rd;
  logic [14:0]         r_base;
  logic                r_err;
  logic [STALL_W-1:0]  r_stall;

  logic [14:0]         w_used;
  logic [14:0]         w_free;
  logic                w_alloc_illegal;
  logic                w_alloc_accept;
  logic                w_rel_zero;
  logic                w_rel_accept;
  logic                w_err_set;

  // Occupancy is a pure decode of the registered pointers.
  assign w_used = r_wr - r_rd;
  assign w_free = CAP_L - w_used;

  // Zero-length or oversize allocates are acked and dropped with an error.
  assign w_alloc_illegal = (iAllocLen == 15'd0) || (iAllocLen > CAP_L);
  assign w_rel_zero      = (iRelLen == 15'd0);

  // Release readiness uses pre-update occupancy, so a same-cycle allocate
  // never makes room for a release and vice versa.
  assign oRelReady    = iRelValid && (w_rel_zero || (iRelLen <= w_used));
  assign w_rel_accept = oRelReady && !w_rel_zero;

  // Allocate FSM: next-state and outputs
  always_comb begin
    w_state_next   = r_state;
    oAllocReady    = 1'b0;
    oAllocDone     = 1'b0;
    w_alloc_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        oAllocReady    = iAllocValid && (w_alloc_illegal || (iAllocLen <= w_free));
        w_alloc_accept = oAllocReady && !w_alloc_illegal;
        if (w_alloc_accept) begin
          w_state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        oAllocDone   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_err_set = (oAllocReady && w_alloc_illegal) || (oRelReady && w_rel_zero);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_base  <= '0;
      r_err   <= 1'b0;
      r_stall <= '0;
    end else begin
      if (w_alloc_accept) begin
        r_base <= r_wr;
        r_wr   <= r_wr + iAllocLen;
      end
      if (w_rel_accept) begin
        r_rd <= r_rd + iRelLen;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      // Counts GRANT cycles too; holds at all-ones.
      if (iAllocValid && !oAllocReady && !(&r_stall)) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  assign oAllocBase = r_base;
  assign oWrPtr     = r_wr;
  assign oRdPtr     = r_rd;
  assign oUsed      = w_used;
  assign oFree      = w_free;
  assign oFull      = (w_used == CAP_L);
  assign oEmpty     = (w_used == 15'd0);
  assign oError     = r_err;
  assign oStallCnt  = r_stall;

endmodule

// File: tb/tb_c_ring_alloc.sv
// ---------------------------------------------------------------------------
// tb_c_ring_alloc
//   Directed self-checking bench for c_ring_alloc with CAP=100.
//   Inputs change 1 time unit after a rising edge; all outputs are sampled
//   there as well, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_c_ring_alloc;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iAllocValid;
  logic [14:0] iAllocLen;
  logic        oAllocReady;
  logic        oAllocDone;
  logic [14:0] oAllocBase;
  logic        iRelValid;
  logic [14:0] iRelLen;
  logic        oRelReady;
  logic [14:0] oWrPtr;
  logic [14:0] oRdPtr;
  logic [14:0] oUsed;
  logic [14:0] oFree;
  logic        oFull;
  logic        oEmpty;
  logic        oError;
  logic [15:0] oStallCnt;

  int checks   = 0;
  int failures = 0;

  c_ring_alloc #(.CAP(100), .STALL_W(16)) dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iAllocValid (iAllocValid),
    .iAllocLen   (iAllocLen),
    .oAllocReady (oAllocReady),
    .oAllocDone  (oAllocDone),
    .oAllocBase  (oAllocBase),
    .iRelValid   (iRelValid),
    .iRelLen     (iRelLen),
    .oRelReady   (oRelReady),
    .oWrPtr      (oWrPtr),
    .oRdPtr      (oRdPtr),
    .oUsed       (oUsed),
    .oFree       (oFree),
    .oFull       (oFull),
    .oEmpty      (oEmpty),
    .oError      (oError),
    .oStallCnt   (oStallCnt)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr"},    32'(oWrPtr),     0);
    chk({tag, "_rd"},    32'(oRdPtr),     0);
    chk({tag, "_used"},  32'(oUsed),      0);
    chk({tag, "_free"},  32'(oFree),      100);
    chk({tag, "_empty"}, 32'(oEmpty),     1);
    chk({tag, "_full"},  32'(oFull),      0);
    chk({tag, "_done"},  32'(oAllocDone), 0);
    chk({tag, "_base"},  32'(oAllocBase), 0);
    chk({tag, "_err"},   32'(oError),     0);
    chk({tag, "_stall"}, 32'(oStallCnt),  0);
  endtask

  // Hard time limit so the run always ends even if the DUT wedges.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iReset = 1'b1; iAllocValid = 1'b0; iAllocLen = '0; iRelValid = 1'b0; iRelLen = '0;
    tick(); tick();
    iReset = 1'b0;
    $display("step reset");
    chk_reset_state("rst");

    // Alloc 30 from empty: accept now, Done next cycle with Base=0.
    iAllocValid = 1'b1; iAllocLen = 15'd30; #1;
    $display("step alloc30");
    chk("a30_ready", 32'(oAllocReady), 1);
    tick(); iAllocValid = 1'b0;
    chk("a30_done", 32'(oAllocDone), 1);
    chk("a30_base", 32'(oAllocBase), 0);
    chk("a30_wr",   32'(oWrPtr),     30);
    chk("a30_used", 32'(oUsed),      30);
    chk("a30_free", 32'(oFree),      70);
    tick();
    chk("a30_done_clr", 32'(oAllocDone), 0);

    // Fill to 90.
    iAllocValid = 1'b1; iAllocLen = 15'd60; #1;
    $display("step alloc60");
    chk("a60_ready", 32'(oAllocReady), 1);
    tick(); iAllocValid = 1'b0;
    tick();
    chk("a60_used", 32'(oUsed), 90);

    // Alloc 20 with free=10: stalls and counts.
    iAllocValid = 1'b1; iAllocLen = 15'd20; #1;
    $display("step alloc20 stall");
    chk("a20_ready0", 32'(oAllocReady), 0);
    tick(); tick(); tick();
    chk("a20_stall3", 32'(oStallCnt), 3);
    // Release 15 while still stalled: release accepted, alloc not yet.
    iRelValid = 1'b1; iRelLen = 15'd15; #1;
    $display("step rel15");
    chk("r15_ready",  32'(oRelReady),   1);
    chk("r15_aready", 32'(oAllocReady), 0);
    tick(); iRelValid = 1'b0; #1;
    chk("r15_used",   32'(oUsed),      75);
    chk("r15_stall4", 32'(oStallCnt),  4);
    chk("a20_ready1", 32'(oAllocReady), 1);
    tick(); iAllocValid = 1'b0;
    $display("step alloc20 grant");
    chk("a20_done", 32'(oAllocDone), 1);
    chk("a20_base", 32'(oAllocBase), 90);
    chk("a20_wr",   32'(oWrPtr),     110);
    chk("a20_used", 32'(oUsed),      95);
    chk("a20_free", 32'(oFree),      5);
    tick();
    chk("a20_stall_hold", 32'(oStallCnt), 4);

    // Top up to full, then simultaneous alloc 5 / release 5.
    iAllocValid = 1'b1; iAllocLen = 15'd5;
    tick(); iAllocValid = 1'b0;
    tick();
    $display("step full");
    chk("full_used", 32'(oUsed), 100);
    chk("full_full", 32'(oFull), 1);
    chk("full_free", 32'(oFree), 0);
    iAllocValid = 1'b1; iAllocLen = 15'd5; iRelValid = 1'b1; iRelLen = 15'd5; #1;
    $display("step simul alloc5 rel5");
    chk("sim_aready", 32'(oAllocReady), 0);
    chk("sim_rready", 32'(oRelReady),   1);
    tick(); iAllocValid = 1'b0; iRelValid = 1'b0;
    chk("sim_used", 32'(oUsed),      95);
    chk("sim_full", 32'(oFull),      0);
    chk("sim_done", 32'(oAllocDone), 0);
    chk("sim_rd",   32'(oRdPtr),     20);
    chk("sim_wr",   32'(oWrPtr),     115);

    // Zero-length allocate and release: acked, dropped, error set.
    iAllocValid = 1'b1; iAllocLen = 15'd0; iRelValid = 1'b1; iRelLen = 15'd0; #1;
    $display("step zero-length");
    chk("z_aready", 32'(oAllocReady), 1);
    chk("z_rready", 32'(oRelReady),   1);
    tick(); iAllocValid = 1'b0; iRelValid = 1'b0;
    chk("z_done", 32'(oAllocDone), 0);
    chk("z_err",  32'(oError),     1);
    chk("z_wr",   32'(oWrPtr),     115);
    chk("z_rd",   32'(oRdPtr),     20);

    // Oversize allocate acked and dropped; over-used release held, not acked.
    iAllocValid = 1'b1; iAllocLen = 15'd101; iRelValid = 1'b1; iRelLen = 15'd96; #1;
    $display("step oversize/over-release");
    chk("ov_aready", 32'(oAllocReady), 1);
    chk("ov_rready", 32'(oRelReady),   0);
    tick(); iAllocValid = 1'b0; iRelValid = 1'b0;
    tick();
    chk("ov_done",  32'(oAllocDone), 0);
    chk("ov_wr",    32'(oWrPtr),     115);
    chk("ov_rd",    32'(oRdPtr),     20);
    chk("ov_err",   32'(oError),     1);

    // Reset clears the sticky error, then walk pointers to 32760.
    iReset = 1'b1; tick(); iReset = 1'b0;
    $display("step reset2");
    chk("rst2_err", 32'(oError), 0);
    chk("rst2_wr",  32'(oWrPtr), 0);
    for (int i = 0; i < 546; i++) begin
      iAllocValid = 1'b1; iAllocLen = 15'd60;
      tick();
      iAllocValid = 1'b0; iRelValid = 1'b1; iRelLen = 15'd60;
      tick();
      iRelValid = 1'b0;
    end
    $display("step preload");
    chk("pre_wr",    32'(oWrPtr), 32760);
    chk("pre_rd",    32'(oRdPtr), 32760);
    chk("pre_empty", 32'(oEmpty), 1);

    // Wrap.
    iAllocValid = 1'b1; iAllocLen = 15'd10;
    tick(); iAllocValid = 1'b0;
    $display("step wrap alloc10");
    chk("wrap_wr",   32'(oWrPtr),     2);
    chk("wrap_used", 32'(oUsed),      10);
    chk("wrap_base", 32'(oAllocBase), 32760);
    chk("wrap_done", 32'(oAllocDone), 1);
    iRelValid = 1'b1; iRelLen = 15'd10;
    tick(); iRelValid = 1'b0;
    $display("step wrap rel10");
    chk("wrap_rd",    32'(oRdPtr), 2);
    chk("wrap_empty", 32'(oEmpty), 1);

    // Reset during GRANT.
    iAllocValid = 1'b1; iAllocLen = 15'd30;
    tick(); iAllocValid = 1'b0;
    $display("step reset in grant");
    chk("rg_done_pre", 32'(oAllocDone), 1);
    iReset = 1'b1;
    tick(); iReset = 1'b0;
    chk_reset_state("rg");
    // FSM back in IDLE: a fresh alloc is accepted immediately.
    iAllocValid = 1'b1; iAllocLen = 15'd7; #1;
    chk("rg_idle_ready", 32'(oAllocReady), 1);
    tick(); iAllocValid = 1'b0;
    chk("rg_wr", 32'(oWrPtr), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c_ring_alloc.md
# c_ring_alloc

Space allocator and pointer manager for a 15-bit-addressed circular buffer. It is the writer/reader bookkeeping counterpart to the 15-bit modular subtractor used for occupancy. It takes allocate requests (producer side) and release requests (consumer side), advances wrapping 15-bit write and read pointers, and reports used/free occupancy, computed as write pointer minus read pointer mod 2^15. It sits in the tb model tree as the buffer-credit model for the NAND page-buffer and DMA-path models.

## Interface
- CAP, 100, usable capacity in entries; legal range 1..32767. CAP=32768 is illegal because full and empty would be indistinguishable.
- STALL_W, 16, width of the saturating stall counter.

Ports:
- iClock  in  1  single clock, rising edge.
- iReset  in  1  synchronous, active-high reset.
- iAllocValid  in  1  allocate request.
- iAllocLen  in  15  entries requested.
- oAllocReady  out  1  allocate accepted this cycle when high with iAllocValid.
- oAllocDone  out  1  one-cycle pulse, one cycle after an accepted allocate.
- oAllocBase  out  15  start pointer of the granted region; valid with oAllocDone, held otherwise.
- iRelValid  in  1  release request.
- iRelLen  in  15  entries released.
- oRelReady  out  1  release accepted this cycle when high with iRelValid.
- oWrPtr  out  15  write pointer.
- oRdPtr  out  15  read pointer.
- oUsed  out  15  entries in use, equal to oWrPtr − oRdPtr mod 2^15.
- oFree  out  15  CAP − oUsed.
- oFull  out  1  oUsed == CAP.
- oEmpty  out  1  oUsed == 0.
- oError  out  1  sticky protocol error flag.
- oStallCnt  out  STALL_W  saturating count of cycles with iAllocValid high and oAllocReady low.

## Operation
- Reset: all pointers = 0, oUsed = 0, oFree = CAP, oEmpty = 1, oFull = 0, oAllocDone = 0, oAllocBase = 0, oError = 0, oStallCnt = 0.
- All arithmetic is 15-bit, unsigned, mod 2^15. Carry and borrow are discarded. Pointers wrap naturally: 32760 + 10 → 2.
- Allocate FSM, two states:
  - IDLE: oAllocReady = iAllocValid && 1 ≤ iAllocLen ≤ oFree, using registered oFree. On accept: latch oAllocBase = oWrPtr, oWrPtr += iAllocLen, go to GRANT.
  - GRANT: lasts exactly one cycle. oAllocDone = 1, oAllocReady = 0, return to IDLE.
  - The FSM therefore accepts at most one allocate every 2 cycles.
- Illegal allocate (iAllocLen == 0 or iAllocLen > CAP): in IDLE it is acked (oAllocReady = 1) and dropped. The pointer is unchanged, there is no oAllocDone, and oError is set.
- Release: oRelReady = iRelValid && 1 ≤ iRelLen ≤ oUsed, using registered oUsed. On accept, oRdPtr += iRelLen. A release can be accepted every cycle.
- Release with iRelLen == 0: acked and dropped, oError set.
- Release with iRelLen > oUsed: not acked and held, no error. It is accepted once enough entries are allocated.
- Simultaneous allocate and release accept in the same cycle: both pointers update. Readiness is judged on pre-update oUsed/oFree, so a release never creates room for an allocate in the same cycle.
- oStallCnt increments whenever iAllocValid is high and oAllocReady is low, including GRANT cycles. It saturates at all-ones.
- oError is cleared only by iReset.
- Requesters must hold Valid and Len stable until Ready. Behaviour under changed Len is defined per cycle only: evaluation always uses the current Len.

## Timing
- oAllocReady and oRelReady are combinational from inputs plus registered state. No other output is combinational.
- oWrPtr, oRdPtr, oUsed, oFree, oFull and oEmpty all update on the edge after the accepting cycle, with one-cycle latency.
- oAllocDone and oAllocBase are registered and appear one cycle after accept.
- Reset asserted mid-GRANT: the next cycle is IDLE with all reset values. The pending oAllocDone is lost.
- Back-to-back allocates: accept at cycle t, Done at t+1, next accept earliest at t+2.

## Test plan
- Reset, then alloc Len=30 → Ready at t, Done at t+1 with Base=0; oWrPtr=30, oUsed=30, oFree=70.
- CAP=100, used=90, alloc Len=20 → Ready stays 0 and oStallCnt counts. Release Len=15 → next cycle oUsed=75, then the alloc is accepted with Base=90.
- Wrap: pointers preloaded to 32760 by alloc/release cycling, alloc Len=10 → oWrPtr=2, oUsed=10. Release 10 → oRdPtr=2, oEmpty=1.
- Same-cycle alloc Len=5 and release Len=5 at used=100 (full) → alloc rejected, release accepted, oUsed=95 next cycle.
- Alloc Len=0 and release Len=0 → both acked, no Done, oError=1, pointers unchanged. oError stays 1 until iReset.
- Reset asserted during GRANT → oAllocDone=0 and all outputs at reset values next cycle.
